// File: rtl/rom_stream_loader.sv
// ROM image loader: selects one byte-stream source, parses a 32-byte header,
// then streams the ROM payload out as packed little-endian words while
// accumulating a 16-bit checksum that is compared against the header.
module rom_stream_loader #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned OUT_BYTES   = 2,
  parameter int unsigned ROM_MAX_LOG = 13,
  parameter int unsigned RAM_MAX_LOG = 8,
  parameter int unsigned CHECK_SUM   = 1
) (
  input  logic                   wclk,
  input  logic                   resetn,
  input  logic [NCH-1:0]         start,
  input  logic [NCH*8-1:0]       src_data,
  input  logic [NCH-1:0]         src_valid,
  output logic [NCH-1:0]         src_ready,
  output logic [OUT_BYTES*8-1:0] dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   loading,
  output logic                   done,
  output logic                   fail,
  output logic [1:0]             fail_code,
  output logic [7:0]             map_ctrl,
  output logic [7:0]             rom_type_header,
  output logic [3:0]             rom_size,
  output logic [3:0]             ram_size,
  output logic [23:0]            rom_mask,
  output logic [23:0]            ram_mask,
  output logic [15:0]            checksum
);

  localparam int unsigned SELW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned LANEW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_META, S_ROM, S_DONE, S_FAIL} state_t;

  state_t                 state_q, state_d;
  logic [SELW-1:0]        sel_q, sel_d;
  logic [5:0]             off_q, off_d;
  logic [23:0]            cnt_q, cnt_d;
  logic                   rx_done_q, rx_done_d;
  logic [OUT_BYTES*8-1:0] pack_q, pack_d;
  logic [OUT_BYTES*8-1:0] dout_q, dout_d;
  logic                   dvalid_q, dvalid_d;
  logic                   loading_q, loading_d;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;
  logic [1:0]             code_q, code_d;
  logic [7:0]             map_q, map_d;
  logic [7:0]             type_q, type_d;
  logic [3:0]             romsz_q, romsz_d;
  logic [3:0]             ramsz_q, ramsz_d;
  logic [23:0]            rommask_q, rommask_d;
  logic [23:0]            rammask_q, rammask_d;
  logic [15:0]            csum_q, csum_d;
  logic [15:0]            hsum_q, hsum_d;

  logic                   any_start;
  logic                   start_found;
  logic [SELW-1:0]        start_sel;
  logic                   ready_sel;
  logic                   acc;
  logic [7:0]             byte_w;
  logic [LANEW-1:0]       lane;

  // Lowest-index start request wins.
  always_comb begin
    start_sel   = '0;
    start_found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (start[i] && !start_found) begin
        start_sel   = SELW'(i);
        start_found = 1'b1;
      end
    end
    any_start = start_found;
  end

  // Next-state, datapath updates and per-channel ready.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    rx_done_d = rx_done_q;
    pack_d    = pack_q;
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;
    loading_d = loading_q;
    done_d    = done_q;
    fail_d    = fail_q;
    code_d    = code_q;
    map_d     = map_q;
    type_d    = type_q;
    romsz_d   = romsz_q;
    ramsz_d   = ramsz_q;
    rommask_d = rommask_q;
    rammask_d = rammask_q;
    csum_d    = csum_q;
    hsum_d    = hsum_q;

    byte_w = src_data[{sel_q, 3'b000} +: 8];
    lane   = (OUT_BYTES > 1) ? cnt_q[LANEW-1:0] : '0;

    // A byte arriving alongside a start would be discarded by the restart,
    // so ready is withheld on that cycle rather than silently dropping it.
    ready_sel = 1'b0;
    if (state_q == S_META)
      ready_sel = !off_q[5];
    else if (state_q == S_ROM)
      ready_sel = !rx_done_q && (!dvalid_q || dout_ready);
    if (any_start)
      ready_sel = 1'b0;
    src_ready         = '0;
    src_ready[sel_q]  = ready_sel;
    acc               = ready_sel && src_valid[sel_q];

    if (any_start) begin
      state_d   = S_META;
      sel_d     = start_sel;
      off_d     = '0;
      cnt_d     = '0;
      rx_done_d = 1'b0;
      pack_d    = '0;
      dout_d    = '0;
      dvalid_d  = 1'b0;
      loading_d = 1'b1;
      done_d    = 1'b0;
      fail_d    = 1'b0;
      code_d    = 2'd0;
      map_d     = '0;
      type_d    = '0;
      romsz_d   = '0;
      ramsz_d   = '0;
      rommask_d = '0;
      rammask_d = '0;
      csum_d    = '0;
      hsum_d    = '0;
    end else begin
      unique case (state_q)
        S_META: begin
          if (off_q[5]) begin
            if (32'(ramsz_q) > RAM_MAX_LOG) begin
              state_d = S_FAIL; fail_d = 1'b1; code_d = 2'd1; loading_d = 1'b0;
            end else if (32'(romsz_q) > ROM_MAX_LOG) begin
              state_d = S_FAIL; fail_d = 1'b1; code_d = 2'd2; loading_d = 1'b0;
            end else begin
              state_d = S_ROM;
            end
          end else if (acc) begin
            off_d = off_q + 6'd1;
            case (off_q[4:0])
              5'h15: map_d  = byte_w;
              5'h16: type_d = byte_w;
              5'h17: begin
                romsz_d   = byte_w[3:0];
                rommask_d = (24'h400 << byte_w[3:0]) - 24'd1;
              end
              5'h18: begin
                ramsz_d   = byte_w[3:0];
                rammask_d = (24'h400 << byte_w[3:0]) - 24'd1;
              end
              5'h1E: hsum_d[7:0]  = byte_w;
              5'h1F: hsum_d[15:8] = byte_w;
              default: ;
            endcase
          end
        end
        S_ROM: begin
          if (dvalid_q && dout_ready)
            dvalid_d = 1'b0;
          if (acc) begin
            csum_d                      = csum_q + {8'd0, byte_w};
            cnt_d                       = cnt_q + 24'd1;
            pack_d[{lane, 3'b000} +: 8] = byte_w;
            if (lane == LANEW'(OUT_BYTES - 1)) begin
              dout_d   = pack_d;
              dvalid_d = 1'b1;
            end
            if (cnt_q == rommask_q)
              rx_done_d = 1'b1;
          end
          // Payload length is a multiple of the word size, so the last
          // byte always completes a word; finish when that word leaves.
          if (rx_done_q && dvalid_q && dout_ready) begin
            loading_d = 1'b0;
            if (CHECK_SUM != 0 && csum_q != hsum_q) begin
              state_d = S_FAIL; fail_d = 1'b1; code_d = 2'd3;
            end else begin
              state_d = S_DONE; done_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge wclk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      rx_done_q <= 1'b0;
      pack_q    <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      code_q    <= '0;
      map_q     <= '0;
      type_q    <= '0;
      romsz_q   <= '0;
      ramsz_q   <= '0;
      rommask_q <= '0;
      rammask_q <= '0;
      csum_q    <= '0;
      hsum_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      rx_done_q <= rx_done_d;
      pack_q    <= pack_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      loading_q <= loading_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      code_q    <= code_d;
      map_q     <= map_d;
      type_q    <= type_d;
      romsz_q   <= romsz_d;
      ramsz_q   <= ramsz_d;
      rommask_q <= rommask_d;
      rammask_q <= rammask_d;
      csum_q    <= csum_d;
      hsum_q    <= hsum_d;
    end
  end

  assign dout            = dout_q;
  assign dout_valid      = dvalid_q;
  assign loading         = loading_q;
  assign done            = done_q;
  assign fail            = fail_q;
  assign fail_code       = code_q;
  assign map_ctrl        = map_q;
  assign rom_type_header = type_q;
  assign rom_size        = romsz_q;
  assign ram_size        = ramsz_q;
  assign rom_mask        = rommask_q;
  assign ram_mask        = rammask_q;
  assign checksum        = csum_q;

endmodule

// File: tb/tb_rom_stream_loader.sv
// Scoreboard bench for rom_stream_loader: expected words are queued as the
// source bytes are accepted and popped as the sink consumes output words.
module tb_rom_stream_loader;

  localparam int NCH = 2;
  localparam int OB  = 2;

  logic              wclk = 1'b0;
  logic              resetn = 1'b0;
  logic [NCH-1:0]    start = '0;
  logic [NCH*8-1:0]  src_data = '0;
  logic [NCH-1:0]    src_valid = '0;
  logic [NCH-1:0]    src_ready;
  logic [OB*8-1:0]   dout;
  logic              dout_valid;
  logic              dout_ready = 1'b1;
  logic              loading, done, fail;
  logic [1:0]        fail_code;
  logic [7:0]        map_ctrl, rom_type_header;
  logic [3:0]        rom_size, ram_size;
  logic [23:0]       rom_mask, ram_mask;
  logic [15:0]       checksum;

  rom_stream_loader #(.NCH(NCH), .OUT_BYTES(OB), .ROM_MAX_LOG(13),
                      .RAM_MAX_LOG(8), .CHECK_SUM(1)) dut (
    .wclk(wclk), .resetn(resetn), .start(start), .src_data(src_data),
    .src_valid(src_valid), .src_ready(src_ready), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .loading(loading),
    .done(done), .fail(fail), .fail_code(fail_code), .map_ctrl(map_ctrl),
    .rom_type_header(rom_type_header), .rom_size(rom_size),
    .ram_size(ram_size), .rom_mask(rom_mask), .ram_mask(ram_mask),
    .checksum(checksum));

  always #5 wclk = ~wclk;

  int          passed = 0;
  int          total  = 0;
  logic [15:0] qexp[$];
  logic [7:0]  hdr[32];
  logic [15:0] psum;
  int          words, hold_err, other_err, saw_valid, timeout;

  function automatic logic [7:0] pay(input int i, input int seed);
    return 8'((i * 37) + (i >> 7) + seed * 13);
  endfunction

  task automatic build_hdr(input int rs, input int rms, input int delta, input int seed);
    logic [15:0] s;
    s = '0;
    if (rs <= 4)
      for (int i = 0; i < (1024 << rs); i++) s = s + {8'd0, pay(i, seed)};
    psum = s;
    for (int i = 0; i < 32; i++) hdr[i] = 8'(8'hA0 ^ i);
    hdr[21] = 8'(8'h20 + seed);
    hdr[22] = 8'h5A;
    hdr[23] = 8'h30 | 8'(rs);
    hdr[24] = 8'h50 | 8'(rms);
    s = s + 16'(delta);
    hdr[30] = s[7:0];
    hdr[31] = s[15:8];
  endtask

  // Entered at a negedge; leaves one negedge after the start pulse.
  task automatic do_start(input int ch);
    src_valid = '0;
    start = '0;
    start[ch] = 1'b1;
    @(negedge wclk);
    start = '0;
  endtask

  task automatic stream(input int ch, input int seed, input int nbytes,
                        input int pct, input int abort_at);
    int idx, cyc;
    logic [15:0] pk, exp_w;
    logic [7:0] b;
    idx = 0; cyc = 0; pk = '0; b = '0;
    words = 0; hold_err = 0; other_err = 0; saw_valid = 0; timeout = 0;
    forever begin
      if (abort_at >= 0 && idx - 32 == abort_at) break;
      dout_ready = ($urandom_range(99) >= pct);
      src_valid = '0;
      src_valid[1-ch] = 1'b1;
      src_data = 16'($urandom);
      if (idx < 32 + nbytes) begin
        b = (idx < 32) ? hdr[idx] : pay(idx - 32, seed);
        src_valid[ch] = 1'b1;
        src_data[ch*8 +: 8] = b;
      end
      #1;
      if (src_ready[1-ch]) other_err++;
      if (dout_valid && !dout_ready && src_ready[ch]) hold_err++;
      if (dout_valid) saw_valid = 1;
      if (src_valid[ch] && src_ready[ch]) begin
        if (idx >= 32) begin
          if (((idx - 32) % OB) == 0) pk[7:0] = b;
          else begin pk[15:8] = b; qexp.push_back(pk); end
        end
        idx++;
      end
      if (dout_valid && dout_ready) begin
        words++;
        total++;
        if (qexp.size() == 0)
          $display("FAIL word_unexpected: got %h, required no word", dout);
        else begin
          exp_w = qexp.pop_front();
          if (dout !== exp_w)
            $display("FAIL word[%0d]: got %h, required %h", words - 1, dout, exp_w);
          else passed++;
        end
      end
      if (done || fail) break;
      cyc++;
      if (cyc > 40000) begin timeout = 1; break; end
      @(negedge wclk);
    end
    src_valid = '0;
    dout_ready = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start = 2'b01;
    repeat (3) @(negedge wclk);
    #1;
    total++; if (loading !== 1'b0) $display("FAIL reset_loading: got %b, required 0", loading); else passed++;
    total++; if ({done, fail, dout_valid} !== 3'b000) $display("FAIL reset_status: got %b, required 000", {done, fail, dout_valid}); else passed++;
    total++; if (src_ready !== 2'b00) $display("FAIL reset_src_ready: got %b, required 00", src_ready); else passed++;
    total++; if ({rom_mask, ram_mask, checksum} !== 64'd0) $display("FAIL reset_masks_sum: got %h, required 0", {rom_mask, ram_mask, checksum}); else passed++;
    start = '0;
    resetn = 1'b1;
    @(negedge wclk);
    total++; if (loading !== 1'b0) $display("FAIL idle_loading: got %b, required 0", loading); else passed++;
  endtask

  task automatic test_basic;
    build_hdr(1, 3, 0, 5);
    do_start(0);
    stream(0, 5, 2048, 0, -1);
    total++; if (timeout !== 0) $display("FAIL basic_timeout: got %0d, required 0", timeout); else passed++;
    total++; if (words !== 1024) $display("FAIL basic_words: got %0d, required 1024", words); else passed++;
    total++; if (qexp.size() !== 0) $display("FAIL basic_leftover: got %0d, required 0", qexp.size()); else passed++;
    total++; if ({done, fail, loading} !== 3'b100) $display("FAIL basic_status: got %b, required 100", {done, fail, loading}); else passed++;
    total++; if (rom_mask !== 24'h7FF) $display("FAIL basic_rom_mask: got %h, required 7ff", rom_mask); else passed++;
    total++; if (ram_mask !== 24'h1FFF) $display("FAIL basic_ram_mask: got %h, required 1fff", ram_mask); else passed++;
    total++; if (checksum !== psum) $display("FAIL basic_checksum: got %h, required %h", checksum, psum); else passed++;
    total++; if ({rom_size, ram_size} !== 8'h13) $display("FAIL basic_sizes: got %h, required 13", {rom_size, ram_size}); else passed++;
    total++; if ({map_ctrl, rom_type_header} !== {hdr[21], hdr[22]}) $display("FAIL basic_hdr_fields: got %h, required %h", {map_ctrl, rom_type_header}, {hdr[21], hdr[22]}); else passed++;
    total++; if (other_err !== 0) $display("FAIL basic_other_ready: got %0d, required 0", other_err); else passed++;
    #1;
    total++; if (src_ready !== 2'b00) $display("FAIL done_src_ready: got %b, required 00", src_ready); else passed++;
    @(negedge wclk);
  endtask

  task automatic test_backpressure;
    build_hdr(1, 3, 0, 5);
    do_start(0);
    stream(0, 5, 2048, 30, -1);
    total++; if (timeout !== 0) $display("FAIL bp_timeout: got %0d, required 0", timeout); else passed++;
    total++; if (words !== 1024) $display("FAIL bp_words: got %0d, required 1024", words); else passed++;
    total++; if (hold_err !== 0) $display("FAIL bp_ready_while_held: got %0d, required 0", hold_err); else passed++;
    total++; if ({done, fail_code} !== 3'b100) $display("FAIL bp_done: got %b, required 100", {done, fail_code}); else passed++;
    @(negedge wclk);
  endtask

  task automatic test_boundary;
    build_hdr(0, 8, 0, 7);
    do_start(0);
    stream(0, 7, 1024, 10, -1);
    total++; if (words !== 512) $display("FAIL bnd_words: got %0d, required 512", words); else passed++;
    total++; if ({done, fail} !== 2'b10) $display("FAIL bnd_status: got %b, required 10", {done, fail}); else passed++;
    total++; if ({rom_mask, ram_mask} !== {24'h3FF, 24'h3FFFF}) $display("FAIL bnd_masks: got %h, required %h", {rom_mask, ram_mask}, {24'h3FF, 24'h3FFFF}); else passed++;
    @(negedge wclk);
    build_hdr(14, 3, 0, 7);
    do_start(0);
    stream(0, 7, 1024, 0, -1);
    total++; if ({fail, fail_code, loading} !== 4'b1100) $display("FAIL bad_rom: got %b, required 1100", {fail, fail_code, loading}); else passed++;
    total++; if (saw_valid !== 0) $display("FAIL bad_rom_dout: got %0d, required 0", saw_valid); else passed++;
    @(negedge wclk);
  endtask

  task automatic test_bad_ram;
    build_hdr(1, 9, 0, 2);
    do_start(0);
    stream(0, 2, 2048, 0, -1);
    total++; if (timeout !== 0) $display("FAIL ram_timeout: got %0d, required 0", timeout); else passed++;
    total++; if ({fail, fail_code, loading, done} !== 5'b10100) $display("FAIL bad_ram: got %b, required 10100", {fail, fail_code, loading, done}); else passed++;
    total++; if (saw_valid !== 0) $display("FAIL bad_ram_dout: got %0d, required 0", saw_valid); else passed++;
    total++; if (qexp.size() !== 0) $display("FAIL bad_ram_payload: got %0d, required 0", qexp.size()); else passed++;
    @(negedge wclk);
  endtask

  task automatic test_checksum;
    build_hdr(1, 3, 1, 6);
    do_start(0);
    stream(0, 6, 2048, 0, -1);
    total++; if (words !== 1024) $display("FAIL cks_words: got %0d, required 1024", words); else passed++;
    total++; if ({fail, fail_code, done, loading} !== 5'b11100) $display("FAIL cks_status: got %b, required 11100", {fail, fail_code, done, loading}); else passed++;
    total++; if (checksum !== psum) $display("FAIL cks_sum: got %h, required %h", checksum, psum); else passed++;
    @(negedge wclk);
  endtask

  task automatic test_abort;
    build_hdr(1, 3, 0, 3);
    do_start(0);
    stream(0, 3, 2048, 0, 500);
    qexp.delete();
    do_start(1);
    #1;
    total++; if (src_ready[0] !== 1'b0) $display("FAIL abort_ch0_ready: got %b, required 0", src_ready[0]); else passed++;
    total++; if (checksum !== 16'd0) $display("FAIL abort_checksum: got %h, required 0", checksum); else passed++;
    total++; if ({loading, dout_valid, done} !== 3'b100) $display("FAIL abort_status: got %b, required 100", {loading, dout_valid, done}); else passed++;
    build_hdr(0, 2, 0, 11);
    stream(1, 11, 1024, 20, -1);
    total++; if (words !== 512) $display("FAIL abort_ch1_words: got %0d, required 512", words); else passed++;
    total++; if ({done, fail} !== 2'b10) $display("FAIL abort_ch1_status: got %b, required 10", {done, fail}); else passed++;
    total++; if (other_err !== 0) $display("FAIL abort_ch0_ignored: got %0d, required 0", other_err); else passed++;
    @(negedge wclk);
  endtask

  task automatic test_reset_mid;
    build_hdr(1, 3, 0, 4);
    do_start(0);
    stream(0, 4, 2048, 0, 300);
    resetn = 1'b0;
    start = 2'b01;
    @(negedge wclk);
    #1;
    total++; if ({loading, done, fail, dout_valid} !== 4'b0000) $display("FAIL rstmid_status: got %b, required 0000", {loading, done, fail, dout_valid}); else passed++;
    total++; if (src_ready !== 2'b00) $display("FAIL rstmid_src_ready: got %b, required 00", src_ready); else passed++;
    total++; if ({rom_mask, ram_mask, checksum, dout} !== 80'd0) $display("FAIL rstmid_data: got %h, required 0", {rom_mask, ram_mask, checksum, dout}); else passed++;
    total++; if ({map_ctrl, rom_type_header, rom_size, ram_size, fail_code} !== 26'd0) $display("FAIL rstmid_hdr: got %h, required 0", {map_ctrl, rom_type_header, rom_size, ram_size, fail_code}); else passed++;
    qexp.delete();
    start = '0;
    resetn = 1'b1;
    @(negedge wclk);
    #1;
    total++; if ({loading, src_ready} !== 3'b000) $display("FAIL rstmid_idle: got %b, required 000", {loading, src_ready}); else passed++;
    @(negedge wclk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_boundary();
    test_bad_ram();
    test_checksum();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
